sprite_position_bank: RTL and testbench
=======================================

SPRITE_POSITION_BANK -- requirements
Module: sprite_position_bank

Interface
REQ-001 Parameter NUM_SPRITES, default 5, meaning number of stored sprites; sprite 0 is Pacman, sprites 1..NUM_SPRITES-1 are ghosts.
REQ-002 Parameter COORD_W, default 5, meaning coordinate width in bits.
REQ-003 Parameter GRID_W, default 21, meaning legal x range 0..GRID_W-1, with GRID_W <= 2^COORD_W.
REQ-004 Parameter GRID_H, default 21, meaning legal y range 0..GRID_H-1, with GRID_H <= 2^COORD_W.
REQ-005 Parameter PAC_X, default 2, and PAC_Y, default 2, meaning the home tile of sprite 0.
REQ-006 Parameter GHOST_X, default 9, and GHOST_Y, default 10, meaning the home of ghost i at (GHOST_X+i-1, GHOST_Y).
REQ-007 Local IDX_W SHALL be max(1, clog2(NUM_SPRITES)).
REQ-008 clock_50  in  1  sole clock; all state changes on its rising edge.
REQ-009 reset_n  in  1  asynchronous, active-low reset.
REQ-010 cmd_valid  in  1  command request.
REQ-011 cmd_ready  out  1  block can accept a command.
REQ-012 cmd_op  in  2  operation: 00 read, 01 write absolute, 10 step, 11 send sprite home.
REQ-013 cmd_idx  in  IDX_W  target sprite.
REQ-014 cmd_dir  in  2  step direction: 00 up (y-1), 01 down (y+1), 10 left (x-1), 11 right (x+1).
REQ-015 x_in, y_in  in  COORD_W each  absolute write coordinates.
REQ-016 rsp_valid  out  1  one-cycle response strobe.
REQ-017 rsp_x, rsp_y  out  COORD_W each  target coordinates after the operation.
REQ-018 rsp_err  out  1  command rejected; valid only with rsp_valid.
REQ-019 all_x, all_y  out  NUM_SPRITES*COORD_W each  flat buses of stored coordinates; sprite i occupies bits [i*COORD_W +: COORD_W].
REQ-020 collide  out  1  registered flag: some ghost shares sprite 0's tile.

Function
REQ-021 The FSM SHALL have exactly three states, IDLE, EXEC and RESP.
REQ-022 cmd_ready SHALL be 1 only in IDLE.
REQ-023 A command SHALL be accepted when cmd_valid & cmd_ready; on acceptance cmd_op, cmd_idx, cmd_dir, x_in and y_in are latched and the FSM goes IDLE->EXEC.
REQ-024 cmd_valid outside IDLE SHALL be ignored, and inputs SHALL NOT be sampled outside acceptance.
REQ-025 In EXEC the FSM SHALL update the target register, go EXEC->RESP, and RESP->IDLE unconditionally; accept-to-rsp_valid latency is 2 cycles and throughput is one command per 3 cycles.
REQ-026 rsp_valid SHALL be high for exactly the RESP cycle, with rsp_x/rsp_y equal to the target's post-EXEC value.
REQ-027 Op 00 SHALL leave all registers unchanged.
REQ-028 Op 01 SHALL load (x_in, y_in) only if x_in < GRID_W and y_in < GRID_H; otherwise no register changes and rsp_err = 1.
REQ-029 Op 10 SHALL move the target one tile with wrap-around: left at x=0 gives GRID_W-1, right at GRID_W-1 gives 0, up at y=0 gives GRID_H-1, down at GRID_H-1 gives 0; the other axis is unchanged.
REQ-030 Op 11 SHALL load the target's home tile.
REQ-031 A latched cmd_idx >= NUM_SPRITES SHALL cause no update and rsp_err = 1, with rsp_x/rsp_y = 0.
REQ-032 Only the target register SHALL change in EXEC; all other sprites hold.
REQ-033 all_x/all_y SHALL be driven directly from the registers with no extra latency.
REQ-034 collide SHALL be registered each cycle from the current register values, i.e. one cycle after the positions, and SHALL be 1 iff some ghost i >= 1 has x and y equal to sprite 0's.

Reset
REQ-035 While reset_n = 0, regardless of clock, the block SHALL hold: FSM = IDLE, sprite 0 at (PAC_X, PAC_Y), ghost i at (GHOST_X+i-1, GHOST_Y), rsp_valid = 0, rsp_err = 0, rsp_x = rsp_y = 0, collide = 0, cmd_ready = 1.
REQ-036 Reset asserted in EXEC or RESP SHALL abort the command with no response, and no partial update SHALL survive.
REQ-037 The first command SHALL be accepted on the first rising edge after reset_n rises, if cmd_valid = 1.

Verification
REQ-038 After reset with defaults, all_x = {12,11,10,9,2} and all_y = {10,10,10,10,2} per sprite 4..0, and collide = 0.
REQ-039 Step sprite 0 left from (0,5) -> rsp_x = 20, rsp_y = 5, rsp_err = 0, rsp_valid 2 cycles after acceptance.
REQ-040 Write sprite 2 with (21,3) -> rsp_err = 1, and all_x/all_y are unchanged.
REQ-041 Write sprite 1 with (2,2) -> collide = 1 one cycle after the all_x update; then op 11 on sprite 1 -> ghost back at (9,10) and collide = 0.
REQ-042 Hold cmd_valid high continuously -> commands are accepted every 3rd cycle, and cmd_ready is low in EXEC and RESP.
REQ-043 Drop reset_n during EXEC of a write to (7,7) -> no rsp_valid, and the target reads its home tile after reset.

Source files
------------

// File: rtl/sprite_position_bank.sv
// Tile-position register bank for Pacman and the ghosts, driven by a three-state
// command FSM (accept, execute, respond) with a registered sprite-0 collision flag.
module sprite_position_bank #(
  parameter int unsigned NUM_SPRITES = 5,
  parameter int unsigned COORD_W     = 5,
  parameter int unsigned GRID_W      = 21,
  parameter int unsigned GRID_H      = 21,
  parameter int unsigned PAC_X       = 2,
  parameter int unsigned PAC_Y       = 2,
  parameter int unsigned GHOST_X     = 9,
  parameter int unsigned GHOST_Y     = 10,
  localparam int unsigned IDX_W      = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
  input  logic                           clock_50,
  input  logic                           reset_n,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic [1:0]                     cmd_op,
  input  logic [IDX_W-1:0]               cmd_idx,
  input  logic [1:0]                     cmd_dir,
  input  logic [COORD_W-1:0]             x_in,
  input  logic [COORD_W-1:0]             y_in,
  output logic                           rsp_valid,
  output logic [COORD_W-1:0]             rsp_x,
  output logic [COORD_W-1:0]             rsp_y,
  output logic                           rsp_err,
  output logic [NUM_SPRITES*COORD_W-1:0] all_x,
  output logic [NUM_SPRITES*COORD_W-1:0] all_y,
  output logic                           collide
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  localparam logic [COORD_W:0]   GridWL = (COORD_W+1)'(GRID_W);
  localparam logic [COORD_W:0]   GridHL = (COORD_W+1)'(GRID_H);
  localparam logic [COORD_W-1:0] MaxX   = COORD_W'(GRID_W - 1);
  localparam logic [COORD_W-1:0] MaxY   = COORD_W'(GRID_H - 1);
  localparam logic [COORD_W-1:0] One    = COORD_W'(1);

  state_e             state_q;
  logic [COORD_W-1:0] pos_x_q [NUM_SPRITES];
  logic [COORD_W-1:0] pos_y_q [NUM_SPRITES];
  logic [1:0]         op_q, dir_q;
  logic [IDX_W-1:0]   idx_q;
  logic [COORD_W-1:0] x_q, y_q;

  logic               idx_ok, upd_err, hit;
  logic [COORD_W-1:0] cur_x, cur_y, home_sel_x, home_sel_y, nxt_x, nxt_y;

  function automatic logic [COORD_W-1:0] home_x(input int unsigned i);
    return (i == 0) ? COORD_W'(PAC_X) : COORD_W'(GHOST_X + i - 1);
  endfunction

  function automatic logic [COORD_W-1:0] home_y(input int unsigned i);
    return (i == 0) ? COORD_W'(PAC_Y) : COORD_W'(GHOST_Y);
  endfunction

  assign cmd_ready = (state_q == StIdle);

  // Next value of the latched target; an invalid index yields an error and a zero response.
  always_comb begin
    idx_ok     = 1'b0;
    cur_x      = '0;
    cur_y      = '0;
    home_sel_x = '0;
    home_sel_y = '0;
    for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        idx_ok     = 1'b1;
        cur_x      = pos_x_q[i];
        cur_y      = pos_y_q[i];
        home_sel_x = home_x(i);
        home_sel_y = home_y(i);
      end
    end
    nxt_x   = cur_x;
    nxt_y   = cur_y;
    upd_err = !idx_ok;
    case (op_q)
      2'b01: begin
        if (({1'b0, x_q} < GridWL) && ({1'b0, y_q} < GridHL)) begin
          nxt_x = x_q;
          nxt_y = y_q;
        end else begin
          upd_err = 1'b1;
        end
      end
      2'b10: begin
        case (dir_q)
          2'b00:   nxt_y = (cur_y == '0)   ? MaxY : cur_y - One;
          2'b01:   nxt_y = (cur_y == MaxY) ? '0   : cur_y + One;
          2'b10:   nxt_x = (cur_x == '0)   ? MaxX : cur_x - One;
          default: nxt_x = (cur_x == MaxX) ? '0   : cur_x + One;
        endcase
      end
      2'b11: begin
        nxt_x = home_sel_x;
        nxt_y = home_sel_y;
      end
      default: ;
    endcase
    if (!idx_ok) begin
      nxt_x = '0;
      nxt_y = '0;
    end
  end

  always_comb begin
    all_x = '0;
    all_y = '0;
    hit   = 1'b0;
    for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
      all_x[i*COORD_W +: COORD_W] = pos_x_q[i];
      all_y[i*COORD_W +: COORD_W] = pos_y_q[i];
    end
    for (int unsigned i = 1; i < NUM_SPRITES; i++) begin
      hit = hit | ((pos_x_q[i] == pos_x_q[0]) && (pos_y_q[i] == pos_y_q[0]));
    end
  end

  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      op_q      <= '0;
      dir_q     <= '0;
      idx_q     <= '0;
      x_q       <= '0;
      y_q       <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_x     <= '0;
      rsp_y     <= '0;
      collide   <= 1'b0;
      for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
        pos_x_q[i] <= home_x(i);
        pos_y_q[i] <= home_y(i);
      end
    end else begin
      collide <= hit;
      case (state_q)
        StIdle: begin
          rsp_valid <= 1'b0;
          if (cmd_valid) begin
            op_q    <= cmd_op;
            dir_q   <= cmd_dir;
            idx_q   <= cmd_idx;
            x_q     <= x_in;
            y_q     <= y_in;
            state_q <= StExec;
          end
        end
        StExec: begin
          for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
            if (!upd_err && (idx_q == IDX_W'(i))) begin
              pos_x_q[i] <= nxt_x;
              pos_y_q[i] <= nxt_y;
            end
          end
          rsp_x     <= nxt_x;
          rsp_y     <= nxt_y;
          rsp_err   <= upd_err;
          rsp_valid <= 1'b1;
          state_q   <= StResp;
        end
        StResp: begin
          rsp_valid <= 1'b0;
          state_q   <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_position_bank.sv
// Scoreboard bench for sprite_position_bank: commands push expected responses,
// a negedge monitor pops and compares them, including accept-to-response latency.
module tb_sprite_position_bank;

  logic        clock_50 = 1'b0;
  logic        reset_n  = 1'b0;
  logic        cmd_valid, cmd_ready, rsp_valid, rsp_err, collide;
  logic [1:0]  cmd_op, cmd_dir;
  logic [2:0]  cmd_idx;
  logic [4:0]  x_in, y_in, rsp_x, rsp_y;
  logic [24:0] all_x, all_y;

  sprite_position_bank dut (
    .clock_50  (clock_50),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_idx   (cmd_idx),
    .cmd_dir   (cmd_dir),
    .x_in      (x_in),
    .y_in      (y_in),
    .rsp_valid (rsp_valid),
    .rsp_x     (rsp_x),
    .rsp_y     (rsp_y),
    .rsp_err   (rsp_err),
    .all_x     (all_x),
    .all_y     (all_y),
    .collide   (collide)
  );

  always #5 clock_50 = ~clock_50;

  int unsigned cyc = 0;
  always @(posedge clock_50) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  x;
    logic [4:0]  y;
    logic        err;
    int unsigned acc;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  logic [4:0] mx[5];
  logic [4:0] my[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic reset_model();
    mx = '{5'd2, 5'd9, 5'd10, 5'd11, 5'd12};
    my = '{5'd2, 5'd10, 5'd10, 5'd10, 5'd10};
  endtask

  function automatic logic [24:0] packx();
    logic [24:0] v;
    for (int i = 0; i < 5; i++) v[i*5 +: 5] = mx[i];
    return v;
  endfunction

  function automatic logic [24:0] packy();
    logic [24:0] v;
    for (int i = 0; i < 5; i++) v[i*5 +: 5] = my[i];
    return v;
  endfunction

  task automatic check_buses(input string tag);
    chk({tag, "_all_x"}, 64'(all_x), 64'(packx()));
    chk({tag, "_all_y"}, 64'(all_y), 64'(packy()));
  endtask

  task automatic check_reset_state();
    check_buses("reset");
    chk("reset_collide", 64'(collide), 64'(0));
    chk("reset_cmd_ready", 64'(cmd_ready), 64'(1));
    chk("reset_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("reset_rsp_err", 64'(rsp_err), 64'(0));
    chk("reset_rsp_xy", 64'({rsp_x, rsp_y}), 64'(0));
  endtask

  // Monitor: every response strobe must match the oldest outstanding expectation.
  always @(negedge clock_50) begin
    if (rsp_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 at cycle %0d, expected no response", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("rsp_x", 64'(rsp_x), 64'(mon_e.x));
        chk("rsp_y", 64'(rsp_y), 64'(mon_e.y));
        chk("rsp_err", 64'(rsp_err), 64'(mon_e.err));
        chk("rsp_latency", 64'(cyc), 64'(mon_e.acc + 1));
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [2:0] idx, input logic [1:0] dir,
                       input logic [4:0] x, input logic [4:0] y,
                       input logic [4:0] ex, input logic [4:0] ey, input logic eerr);
    exp_t e;
    int   t = 0;
    while (!cmd_ready && t < 20) begin
      @(negedge clock_50);
      t++;
    end
    if (!cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: got cmd_ready=0 for 20 cycles, expected 1");
      return;
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_idx   = idx;
    cmd_dir   = dir;
    x_in      = x;
    y_in      = y;
    e.x   = ex;
    e.y   = ey;
    e.err = eerr;
    e.acc = cyc + 1;
    sb.push_back(e);
    if (!eerr && idx < 3'd5) begin
      mx[idx] = ex;
      my[idx] = ey;
    end
    @(posedge clock_50);
    #1;
    cmd_valid = 1'b0;
    x_in      = 5'h1f;
    y_in      = 5'h1f;
    cmd_idx   = 3'd7;
  endtask

  task automatic drain();
    int t = 0;
    while ((sb.size() != 0 || !cmd_ready) && t < 30) begin
      @(negedge clock_50);
      t++;
    end
    if (sb.size() != 0 || !cmd_ready) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending responses, expected 0", sb.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, expected finish");
    $fatal(1);
  end

  initial begin
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_idx   = 3'd0;
    cmd_dir   = 2'b00;
    x_in      = 5'd0;
    y_in      = 5'd0;
    reset_model();
    repeat (3) @(negedge clock_50);
    check_reset_state();
    reset_n = 1'b1;

    // First command goes in on the first edge after reset release.
    issue(2'b00, 3'd0, 2'b00, 5'd0, 5'd0, 5'd2, 5'd2, 1'b0);
    issue(2'b01, 3'd0, 2'b00, 5'd0, 5'd5, 5'd0, 5'd5, 1'b0);
    issue(2'b10, 3'd0, 2'b10, 5'd0, 5'd0, 5'd20, 5'd5, 1'b0);
    issue(2'b10, 3'd0, 2'b11, 5'd0, 5'd0, 5'd0, 5'd5, 1'b0);
    issue(2'b10, 3'd0, 2'b00, 5'd0, 5'd0, 5'd0, 5'd4, 1'b0);
    issue(2'b01, 3'd4, 2'b00, 5'd3, 5'd0, 5'd3, 5'd0, 1'b0);
    issue(2'b10, 3'd4, 2'b00, 5'd0, 5'd0, 5'd3, 5'd20, 1'b0);
    issue(2'b10, 3'd4, 2'b01, 5'd0, 5'd0, 5'd3, 5'd0, 1'b0);
    drain();
    check_buses("steps");

    issue(2'b01, 3'd2, 2'b00, 5'd21, 5'd3, 5'd10, 5'd10, 1'b1);
    drain();
    check_buses("bad_x");
    issue(2'b01, 3'd1, 2'b00, 5'd0, 5'd21, 5'd9, 5'd10, 1'b1);
    issue(2'b01, 3'd5, 2'b00, 5'd1, 5'd1, 5'd0, 5'd0, 1'b1);
    issue(2'b10, 3'd7, 2'b11, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1);
    drain();
    check_buses("bad_idx");

    issue(2'b11, 3'd0, 2'b00, 5'd0, 5'd0, 5'd2, 5'd2, 1'b0);
    issue(2'b11, 3'd4, 2'b00, 5'd0, 5'd0, 5'd12, 5'd10, 1'b0);
    drain();

    // Collision appears one cycle after the ghost lands on Pacman's tile.
    issue(2'b01, 3'd1, 2'b00, 5'd2, 5'd2, 5'd2, 5'd2, 1'b0);
    @(negedge clock_50);
    @(negedge clock_50);
    check_buses("collide_pos");
    chk("collide_lag", 64'(collide), 64'(0));
    @(negedge clock_50);
    chk("collide_set", 64'(collide), 64'(1));
    issue(2'b11, 3'd1, 2'b00, 5'd0, 5'd0, 5'd9, 5'd10, 1'b0);
    drain();
    chk("collide_clear", 64'(collide), 64'(0));
    check_buses("ghost_home");

    // Back-to-back: valid held high, accepts land every third cycle.
    cmd_op    = 2'b00;
    cmd_idx   = 3'd0;
    cmd_valid = 1'b1;
    for (int k = 0; k < 7; k++) begin
      chk("ready_pattern", 64'(cmd_ready), 64'((k % 3) == 0));
      if ((k % 3) == 0) begin
        exp_t e;
        e.x   = 5'd2;
        e.y   = 5'd2;
        e.err = 1'b0;
        e.acc = cyc + 1;
        sb.push_back(e);
      end
      @(posedge clock_50);
      #1;
      if (k == 6) cmd_valid = 1'b0;
      @(negedge clock_50);
    end
    drain();

    // Reset during EXEC of a write: no response and the target stays home.
    cmd_valid = 1'b1;
    cmd_op    = 2'b01;
    cmd_idx   = 3'd3;
    x_in      = 5'd7;
    y_in      = 5'd7;
    @(posedge clock_50);
    #1;
    cmd_valid = 1'b0;
    chk("exec_not_ready", 64'(cmd_ready), 64'(0));
    reset_n = 1'b0;
    reset_model();
    @(negedge clock_50);
    check_reset_state();
    repeat (2) @(negedge clock_50);
    reset_n = 1'b1;
    issue(2'b00, 3'd3, 2'b00, 5'd0, 5'd0, 5'd11, 5'd10, 1'b0);
    drain();
    check_buses("after_abort");

    repeat (3) @(negedge clock_50);
    chk("sb_empty", 64'(sb.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
